math_issue_queue: RTL and testbench
===================================

Name: math_issue_queue

Overview:
- Age-ordered, collapsing issue queue that schedules integer, branch and vector-ALU micro-ops into the EX00 issue stage.
- Holds renamed micro-op tags (ROB id plus physical source registers) and tracks operand readiness from wakeup broadcasts.
- Each cycle it selects the oldest entry whose sources are both ready and presents it on EX00's 18-bit data / valid inputs.

Parameters:
- DEPTH, 8, number of queue entries; must be a power of two, 2..16.
- CNT_BITS, $clog2(DEPTH)+1, localparam, width of the occupancy count.

Ports:
- cpu_clock_i  input  1  core clock; all state updates on the rising edge.
- cpu_reset_ni  input  1  asynchronous, active-low reset.
- flush_i  input  1  pipeline flush; empties the queue.
- enq_valid_i  input  1  enqueue request.
- enq_data_i  input  18  micro-op tag: [5:0] ROB id, [11:6] rs1 phys, [17:12] rs2 phys.
- enq_rs1_rdy_i  input  1  rs1 already ready at rename.
- enq_rs2_rdy_i  input  1  rs2 already ready at rename.
- enq_ready_o  output  1  queue can accept; equals !full.
- wk0_dest_i  input  6  wakeup tag, port 0 (EX00 wakeup_dest).
- wk0_valid_i  input  1  port 0 valid (EX00 wakeup_valid).
- wk1_dest_i  input  6  wakeup tag, port 1 (load/complex unit).
- wk1_valid_i  input  1  port 1 valid.
- issue_en_i  input  1  downstream accepts an issue this cycle.
- issue_data_o  output  18  selected entry tag, to EX00 data_i.
- issue_valid_o  output  1  selected entry valid, to EX00 valid_i.
- count_o  output  CNT_BITS  current occupancy.

Behaviour:
- Reset (asynchronous, cpu_reset_ni=0): all entry valid bits 0, count 0. Outputs: issue_valid_o=0, issue_data_o=0, enq_ready_o=1, count_o=0. Reset may assert mid-operation; the queue is empty on the first edge after release.
- Entry state: valid, 18-bit tag, rdy1, rdy2. Index 0 is the oldest entry; valid entries are contiguous from 0 to count-1.
- Select (combinational from registered state):
  - Choose the lowest index with valid & rdy1 & rdy2.
  - issue_valid_o = found & !flush_i.
  - issue_data_o = tag of the chosen entry, 0 when none is found.
  - Zero-latency path: an entry that is ready at the start of a cycle is issued in that cycle.
- Issue fires when issue_valid_o & issue_en_i. On the next edge the chosen entry is removed and every entry above it shifts down by one, keeping its ready bits.
- Wakeup, applied each edge to every valid entry and to an entry being enqueued:
  - rdyN is set if wk0_valid_i & (wk0_dest_i == rsN), or wk1_valid_i & (wk1_dest_i == rsN).
  - Physical register 0 is always ready.
  - No same-cycle bypass into select: a wakeup seen in cycle T makes the entry selectable in cycle T+1.
- Enqueue is accepted when enq_valid_i & enq_ready_o & !flush_i.
  - The new entry is written at index count, or count-1 if an issue fires in the same cycle.
  - A full queue with a simultaneous issue still rejects the enqueue (enq_ready_o = !full only, no combinational dependency on select).
- Count next = count + enq_accept - issue_fire.
- Flush: all valid bits clear on the next edge, count=0. Enqueue and issue are suppressed in the flush cycle. enq_ready_o is unaffected by flush.
- A wakeup and an issue of the same entry in one cycle are harmless; the entry is removed.
- Two wakeups matching the same entry in one cycle give the same result as one.
- enq_valid_i while full: the request is ignored and no state changes.

Test Plan:
- Reset then enqueue tag {rs2=5, rs1=3, rob=7} with both ready bits 1 → issue_valid_o=1 with issue_data_o=0x05_0C7 in the next cycle; count 1→0 after the issue.
- Enqueue A (rs1=9, not ready), then B (both ready) → B issues first. Pulse wk0 dest=9 in cycle T → A issues at T+1, not at T.
- Fill 8 entries with nothing ready → enq_ready_o=0, count_o=8. A 9th enqueue is ignored. Wake entry 3 → it issues, entries 4..7 shift to 3..6, count=7, enq_ready_o=1.
- Simultaneous enqueue and issue of entry 0 with count=4 → new entry lands at index 3, count stays 4, age order is preserved.
- Enqueue an entry whose rs1 matches wk1 in the same cycle (rdy1=0 at input) → the entry is ready and issues in the following cycle.
- With 5 entries present, assert flush_i alongside an enqueue and a ready entry → issue_valid_o=0 that cycle, count_o=0 next cycle. Asserting cpu_reset_ni=0 mid-stream empties the queue immediately.

Source files
------------

// File: rtl/math_issue_queue_if.sv
// Issue-queue boundary: rename-side enqueue, wakeup broadcasts, and the EX00 issue port.
// Carries no clock or reset; the queue's timing lives in math_issue_queue.
interface math_issue_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_BITS = $clog2(DEPTH) + 1;

    logic                flush_i;
    logic                enq_valid_i;
    logic [17:0]         enq_data_i;
    logic                enq_rs1_rdy_i;
    logic                enq_rs2_rdy_i;
    logic                enq_ready_o;
    logic [5:0]          wk0_dest_i;
    logic                wk0_valid_i;
    logic [5:0]          wk1_dest_i;
    logic                wk1_valid_i;
    logic                issue_en_i;
    logic [17:0]         issue_data_o;
    logic                issue_valid_o;
    logic [CNT_BITS-1:0] count_o;

    modport master (
        output flush_i, enq_valid_i, enq_data_i, enq_rs1_rdy_i, enq_rs2_rdy_i,
        output wk0_dest_i, wk0_valid_i, wk1_dest_i, wk1_valid_i, issue_en_i,
        input  enq_ready_o, issue_data_o, issue_valid_o, count_o
    );

    modport slave (
        input  flush_i, enq_valid_i, enq_data_i, enq_rs1_rdy_i, enq_rs2_rdy_i,
        input  wk0_dest_i, wk0_valid_i, wk1_dest_i, wk1_valid_i, issue_en_i,
        output enq_ready_o, issue_data_o, issue_valid_o, count_o
    );
endinterface

// File: rtl/math_issue_queue.sv
// Age-ordered collapsing issue queue; the oldest ready entry is presented combinationally (zero-latency select).
// Backpressure: enq_ready_o = !full; issue_en_i low holds the selected entry in place.
module math_issue_queue #(
    parameter int DEPTH = 8
) (
    input  logic              cpu_clock_i,
    input  logic              cpu_reset_ni,
    math_issue_queue_if.slave bus
);
    localparam int CNT_BITS = $clog2(DEPTH) + 1;
    localparam int IDX_W    = $clog2(DEPTH);

    typedef logic [17:0] tag_t;

    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    rdy1_q, rdy1_d;
    logic [DEPTH-1:0]    rdy2_q, rdy2_d;
    tag_t                tag_q [DEPTH];
    tag_t                tag_d [DEPTH];
    logic [CNT_BITS-1:0] count_q, count_d;

    logic                found;
    logic [IDX_W-1:0]    sel_idx;
    logic                full;
    logic                issue_fire;
    logic                enq_accept;
    logic [CNT_BITS-1:0] wr_idx;

    // One slot beyond the top reads as empty so the collapse shifts zeros in.
    logic [DEPTH:0]      v_ext, r1_ext, r2_ext;
    tag_t                t_ext [DEPTH+1];

    function automatic logic woken(input logic [5:0] ps,
                                   input logic w0v, input logic [5:0] w0d,
                                   input logic w1v, input logic [5:0] w1d);
        return (ps == 6'd0) || (w0v && (w0d == ps)) || (w1v && (w1d == ps));
    endfunction

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign full       = (count_q == CNT_BITS'(DEPTH));
    assign issue_fire = found && !bus.flush_i && bus.issue_en_i;
    assign enq_accept = bus.enq_valid_i && !full && !bus.flush_i;
    assign wr_idx     = count_q - CNT_BITS'(issue_fire);

    always_comb begin
        v_ext  = {1'b0, valid_q};
        r1_ext = {1'b0, rdy1_q};
        r2_ext = {1'b0, rdy2_q};
        for (int i = 0; i < DEPTH; i++) t_ext[i] = tag_q[i];
        t_ext[DEPTH] = '0;
    end

    always_comb begin
        valid_d = '0;
        rdy1_d  = '0;
        rdy2_d  = '0;
        for (int i = 0; i < DEPTH; i++) tag_d[i] = '0;
        count_d = '0;
        if (!bus.flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_fire && (IDX_W'(i) >= sel_idx)) begin
                    valid_d[i] = v_ext[i+1];
                    rdy1_d[i]  = r1_ext[i+1];
                    rdy2_d[i]  = r2_ext[i+1];
                    tag_d[i]   = t_ext[i+1];
                end else begin
                    valid_d[i] = v_ext[i];
                    rdy1_d[i]  = r1_ext[i];
                    rdy2_d[i]  = r2_ext[i];
                    tag_d[i]   = t_ext[i];
                end
                if (valid_d[i]) begin
                    rdy1_d[i] = rdy1_d[i] | woken(tag_d[i][11:6], bus.wk0_valid_i, bus.wk0_dest_i,
                                                  bus.wk1_valid_i, bus.wk1_dest_i);
                    rdy2_d[i] = rdy2_d[i] | woken(tag_d[i][17:12], bus.wk0_valid_i, bus.wk0_dest_i,
                                                  bus.wk1_valid_i, bus.wk1_dest_i);
                end else begin
                    rdy1_d[i] = 1'b0;
                    rdy2_d[i] = 1'b0;
                    tag_d[i]  = '0;
                end
                // New entry lands just above the surviving entries, after any collapse.
                if (enq_accept && (CNT_BITS'(i) == wr_idx)) begin
                    valid_d[i] = 1'b1;
                    tag_d[i]   = bus.enq_data_i;
                    rdy1_d[i]  = bus.enq_rs1_rdy_i | woken(bus.enq_data_i[11:6], bus.wk0_valid_i,
                                                           bus.wk0_dest_i, bus.wk1_valid_i, bus.wk1_dest_i);
                    rdy2_d[i]  = bus.enq_rs2_rdy_i | woken(bus.enq_data_i[17:12], bus.wk0_valid_i,
                                                           bus.wk0_dest_i, bus.wk1_valid_i, bus.wk1_dest_i);
                end
            end
            count_d = count_q + CNT_BITS'(enq_accept) - CNT_BITS'(issue_fire);
        end
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
            count_q <= count_d;
        end
    end

    assign bus.enq_ready_o   = !full;
    assign bus.issue_valid_o = found && !bus.flush_i;
    assign bus.issue_data_o  = found ? tag_q[sel_idx] : '0;
    assign bus.count_o       = count_q;
endmodule

// File: tb/tb_math_issue_queue.sv
// Directed plus randomized checks of math_issue_queue against a queue-based age-order model.
module tb_math_issue_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [17:0] m_tag [$];
    logic        m_r1  [$];
    logic        m_r2  [$];

    math_issue_queue_if #(.DEPTH(DEPTH)) bus ();

    math_issue_queue #(.DEPTH(DEPTH)) dut (
        .cpu_clock_i (clk),
        .cpu_reset_ni(rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] mk(input int rob, input int rs1, input int rs2);
        logic [5:0] a, b, c;
        a = rob[5:0];
        b = rs1[5:0];
        c = rs2[5:0];
        return {c, b, a};
    endfunction

    function automatic bit mwk(input logic [5:0] p);
        return (p == 6'd0) || (bus.wk0_valid_i && bus.wk0_dest_i == p) ||
               (bus.wk1_valid_i && bus.wk1_dest_i == p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_sel(output bit f, output int s);
        f = 1'b0;
        s = 0;
        for (int i = 0; i < m_tag.size(); i++) begin
            if (m_r1[i] && m_r2[i]) begin
                f = 1'b1;
                s = i;
                break;
            end
        end
    endtask

    task automatic check_model();
        bit f;
        int s;
        model_sel(f, s);
        chk("issue_valid", 32'(bus.issue_valid_o), 32'(f && !bus.flush_i));
        chk("issue_data", 32'(bus.issue_data_o), f ? 32'(m_tag[s]) : 32'd0);
        chk("enq_ready", 32'(bus.enq_ready_o), 32'(m_tag.size() != DEPTH));
        chk("count", 32'(bus.count_o), 32'(m_tag.size()));
    endtask

    task automatic drive(input bit fl, input bit ev, input logic [17:0] d, input bit r1, input bit r2,
                         input bit w0v, input logic [5:0] w0d, input bit w1v, input logic [5:0] w1d,
                         input bit ie);
        bus.flush_i       = fl;
        bus.enq_valid_i   = ev;
        bus.enq_data_i    = d;
        bus.enq_rs1_rdy_i = r1;
        bus.enq_rs2_rdy_i = r2;
        bus.wk0_valid_i   = w0v;
        bus.wk0_dest_i    = w0d;
        bus.wk1_valid_i   = w1v;
        bus.wk1_dest_i    = w1d;
        bus.issue_en_i    = ie;
        #1;
        check_model();
    endtask

    task automatic idle(input bit ie);
        drive(0, 0, 18'd0, 0, 0, 0, 6'd0, 0, 6'd0, ie);
    endtask

    task automatic enq(input logic [17:0] d, input bit r1, input bit r2, input bit ie);
        drive(0, 1, d, r1, r2, 0, 6'd0, 0, 6'd0, ie);
    endtask

    // Advance one clock, updating the model from the inputs currently driven.
    task automatic tick();
        bit f;
        int s;
        bit was_full;
        was_full = (m_tag.size() == DEPTH);
        if (bus.flush_i) begin
            m_tag.delete();
            m_r1.delete();
            m_r2.delete();
        end else begin
            model_sel(f, s);
            if (f && bus.issue_en_i) begin
                m_tag.delete(s);
                m_r1.delete(s);
                m_r2.delete(s);
            end
            for (int i = 0; i < m_tag.size(); i++) begin
                if (mwk(m_tag[i][11:6]))  m_r1[i] = 1'b1;
                if (mwk(m_tag[i][17:12])) m_r2[i] = 1'b1;
            end
            if (bus.enq_valid_i && !was_full) begin
                m_tag.push_back(bus.enq_data_i);
                m_r1.push_back(bus.enq_rs1_rdy_i | mwk(bus.enq_data_i[11:6]));
                m_r2.push_back(bus.enq_rs2_rdy_i | mwk(bus.enq_data_i[17:12]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush_i = 0; bus.enq_valid_i = 0; bus.enq_data_i = '0;
        bus.enq_rs1_rdy_i = 0; bus.enq_rs2_rdy_i = 0; bus.wk0_valid_i = 0; bus.wk0_dest_i = '0;
        bus.wk1_valid_i = 0; bus.wk1_dest_i = '0; bus.issue_en_i = 0;
        #3;
        chk("rst_issue_valid", 32'(bus.issue_valid_o), 32'd0);
        chk("rst_issue_data", 32'(bus.issue_data_o), 32'd0);
        chk("rst_enq_ready", 32'(bus.enq_ready_o), 32'd1);
        chk("rst_count", 32'(bus.count_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single ready entry issues the cycle after enqueue.
        enq(mk(7, 3, 5), 1, 1, 1);
        chk("t1_pre_valid", 32'(bus.issue_valid_o), 32'd0);
        tick();
        idle(1);
        chk("t1_valid", 32'(bus.issue_valid_o), 32'd1);
        chk("t1_data", 32'(bus.issue_data_o), 32'h050C7);
        chk("t1_count1", 32'(bus.count_o), 32'd1);
        tick();
        idle(1);
        chk("t1_count0", 32'(bus.count_o), 32'd0);
        tick();

        // Younger ready entry bypasses older waiting one; wakeup is visible one cycle later.
        enq(mk(1, 9, 10), 0, 1, 0); tick();
        enq(mk(2, 11, 12), 1, 1, 0); tick();
        idle(1);
        chk("t2_b_first", 32'(bus.issue_data_o), 32'(mk(2, 11, 12)));
        tick();
        drive(0, 0, 18'd0, 0, 0, 1, 6'd9, 0, 6'd0, 1);
        chk("t2_no_bypass", 32'(bus.issue_valid_o), 32'd0);
        tick();
        idle(1);
        chk("t2_a_valid", 32'(bus.issue_valid_o), 32'd1);
        chk("t2_a_data", 32'(bus.issue_data_o), 32'(mk(1, 9, 10)));
        tick();

        // Fill to full, reject a ninth, then pull from the middle.
        for (int i = 0; i < DEPTH; i++) begin
            enq(mk(16 + i, 20 + i, 40 + i), 0, 0, 1);
            tick();
        end
        enq(mk(63, 62, 61), 1, 1, 1);
        chk("t3_full_rdy", 32'(bus.enq_ready_o), 32'd0);
        chk("t3_full_cnt", 32'(bus.count_o), 32'd8);
        tick();
        drive(0, 0, 18'd0, 0, 0, 1, 6'd23, 1, 6'd43, 1);
        chk("t3_still_8", 32'(bus.count_o), 32'd8);
        tick();
        idle(1);
        chk("t3_mid_data", 32'(bus.issue_data_o), 32'(mk(19, 23, 43)));
        tick();
        drive(0, 0, 18'd0, 0, 0, 1, 6'd24, 1, 6'd44, 0);
        chk("t3_cnt7", 32'(bus.count_o), 32'd7);
        chk("t3_rdy_back", 32'(bus.enq_ready_o), 32'd1);
        tick();
        idle(1);
        chk("t3_shifted", 32'(bus.issue_data_o), 32'(mk(20, 24, 44)));
        tick();
        drive(1, 0, 18'd0, 0, 0, 0, 6'd0, 0, 6'd0, 0); tick();

        // Enqueue concurrent with issue of entry 0 keeps the count and age order.
        enq(mk(50, 1, 2), 1, 1, 0); tick();
        for (int k = 0; k < 3; k++) begin
            enq(mk(51 + k, 30 + k, 33 + k), 0, 0, 0);
            tick();
        end
        enq(mk(60, 36, 37), 0, 0, 1);
        chk("t4_issue_e0", 32'(bus.issue_data_o), 32'(mk(50, 1, 2)));
        tick();
        drive(0, 0, 18'd0, 0, 0, 1, 6'd30, 1, 6'd33, 0);
        chk("t4_cnt4", 32'(bus.count_o), 32'd4);
        tick();
        drive(0, 0, 18'd0, 0, 0, 1, 6'd36, 1, 6'd37, 0); tick();
        idle(1);
        chk("t4_e1_first", 32'(bus.issue_data_o), 32'(mk(51, 30, 33)));
        tick();
        idle(1);
        chk("t4_new_next", 32'(bus.issue_data_o), 32'(mk(60, 36, 37)));
        tick();
        drive(1, 0, 18'd0, 0, 0, 0, 6'd0, 0, 6'd0, 0); tick();

        // Wakeup coinciding with enqueue sets the ready bit.
        drive(0, 1, mk(5, 40, 41), 0, 1, 0, 6'd0, 1, 6'd40, 1);
        tick();
        idle(1);
        chk("t5_valid", 32'(bus.issue_valid_o), 32'd1);
        chk("t5_data", 32'(bus.issue_data_o), 32'(mk(5, 40, 41)));
        tick();

        // Flush with enqueue and a ready entry present.
        enq(mk(8, 1, 1), 1, 1, 0); tick();
        for (int k = 0; k < 4; k++) begin
            enq(mk(9 + k, 42 + k, 50 + k), 0, 0, 0);
            tick();
        end
        drive(1, 1, mk(14, 3, 3), 1, 1, 0, 6'd0, 0, 6'd0, 1);
        chk("t6_flush_valid", 32'(bus.issue_valid_o), 32'd0);
        chk("t6_cnt5", 32'(bus.count_o), 32'd5);
        tick();
        idle(0);
        chk("t6_cnt0", 32'(bus.count_o), 32'd0);
        tick();

        // Mid-stream asynchronous reset.
        for (int k = 0; k < 3; k++) begin
            enq(mk(20 + k, 1, 2), 1, 1, 0);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("mrst_count", 32'(bus.count_o), 32'd0);
        chk("mrst_valid", 32'(bus.issue_valid_o), 32'd0);
        chk("mrst_ready", 32'(bus.enq_ready_o), 32'd1);
        m_tag.delete();
        m_r1.delete();
        m_r2.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic over a small register space to force tag collisions.
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 70,
                  mk($urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 60);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
